// File: rtl/player_link_pkg.sv
// Shared types and helpers for the inter-board player link.
// Holds the filter state type, the minimum synchroniser depth and the score-step legality rule.
package player_link_pkg;

    typedef enum logic {
        FLT_STABLE   = 1'b0,
        FLT_SETTLING = 1'b1
    } flt_state_e;

    localparam int PL_MIN_SYNC = 2;

    // A peer score may only advance by one (wrapping) or restart at zero.
    function automatic logic score_legal(input logic [31:0] old_s,
                                         input logic [31:0] new_s,
                                         input int          w);
        logic [31:0] mask;
        mask = (w >= 32) ? 32'hFFFF_FFFF : ((32'd1 << w) - 32'd1);
        return (new_s == ((old_s + 32'd1) & mask)) || (new_s == 32'd0);
    endfunction

endpackage

// File: rtl/player_link_filter.sv
// Synchroniser chain plus stability filter for one raw field of one peer.
// Emits a commit strobe with the settled candidate; accept_i lets the owner veto the commit.
module link_filter
    import player_link_pkg::*;
#(
    parameter int W             = 1,
    parameter int SYNC_STAGES   = 2,
    parameter int STABLE_CYCLES = 650000
) (
    input  logic         clk,
    input  logic         rst,
    input  logic [W-1:0] raw_i,
    input  logic         accept_i,
    output logic         commit_o,
    output logic [W-1:0] cand_o
);

    localparam int N_SYNC = (SYNC_STAGES < PL_MIN_SYNC) ? PL_MIN_SYNC : SYNC_STAGES;
    localparam int CNT_W  = $clog2(STABLE_CYCLES);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(STABLE_CYCLES - 1);

    logic [N_SYNC-1:0][W-1:0] sync_q, sync_d;
    logic [W-1:0]             synced;
    flt_state_e               state_q, state_d;
    logic [W-1:0]             cand_q, cand_d;
    logic [W-1:0]             comm_q, comm_d;
    logic [CNT_W-1:0]         cnt_q, cnt_d;

    assign synced = sync_q[N_SYNC-1];
    assign cand_o = cand_q;

    always_comb begin
        sync_d    = sync_q;
        sync_d[0] = raw_i;
        for (int i = 1; i < N_SYNC; i++) begin
            sync_d[i] = sync_q[i-1];
        end
    end

    always_comb begin
        state_d  = state_q;
        cand_d   = cand_q;
        comm_d   = comm_q;
        cnt_d    = cnt_q;
        commit_o = 1'b0;
        case (state_q)
            FLT_STABLE: begin
                if (synced != comm_q) begin
                    cand_d  = synced;
                    cnt_d   = '0;
                    state_d = FLT_SETTLING;
                end
            end
            FLT_SETTLING: begin
                if (synced == comm_q) begin
                    state_d = FLT_STABLE;
                end else if (synced != cand_q) begin
                    cand_d = synced;
                    cnt_d  = '0;
                end else if (cnt_q == CNT_LAST) begin
                    // A vetoed commit falls back to STABLE and retries the full window.
                    commit_o = 1'b1;
                    if (accept_i) comm_d = cand_q;
                    state_d = FLT_STABLE;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            default: state_d = FLT_STABLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sync_q  <= '0;
            state_q <= FLT_STABLE;
            cand_q  <= '0;
            comm_q  <= '0;
            cnt_q   <= '0;
        end else begin
            sync_q  <= sync_d;
            state_q <= state_d;
            cand_q  <= cand_d;
            comm_q  <= comm_d;
            cnt_q   <= cnt_d;
        end
    end

endmodule

// File: rtl/player_link.sv
// Inter-board player link: registers local state out to the pins and filters each peer's inputs.
// Optional PLAYER_LINK_PARITY_EN adds an even-parity bit alongside the score in both directions.
module player_link
    import player_link_pkg::*;
#(
    parameter int N_REMOTE      = 1,
    parameter int SCORE_W       = 4,
    parameter int SYNC_STAGES   = 2,
    parameter int STABLE_CYCLES = 650000
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         clr_err,
    input  logic                         local_pause,
    input  logic                         local_reload,
    input  logic [SCORE_W-1:0]           local_score,
    output logic                         tx_pause,
    output logic                         tx_reload,
    output logic [SCORE_W-1:0]           tx_score,
`ifdef PLAYER_LINK_PARITY_EN
    output logic                         tx_parity,
    input  logic [N_REMOTE-1:0]          rx_parity_raw,
`endif
    input  logic [N_REMOTE-1:0]          rx_pause_raw,
    input  logic [N_REMOTE-1:0]          rx_reload_raw,
    input  logic [N_REMOTE*SCORE_W-1:0]  rx_score_raw,
    output logic [N_REMOTE-1:0]          rx_pause,
    output logic [N_REMOTE-1:0]          rx_reload,
    output logic [N_REMOTE-1:0]          rx_reload_pulse,
    output logic [N_REMOTE*SCORE_W-1:0]  rx_score,
    output logic [N_REMOTE-1:0]          rx_score_upd,
    output logic [N_REMOTE-1:0]          link_err
);

`ifdef PLAYER_LINK_PARITY_EN
    localparam int PAR_W = 1;
`else
    localparam int PAR_W = 0;
`endif
    localparam int SV_W = SCORE_W + PAR_W;

    logic [N_REMOTE-1:0]            pause_commit, pause_cand;
    logic [N_REMOTE-1:0]            reload_commit, reload_cand;
    logic [N_REMOTE-1:0]            score_commit, score_ok;
    logic [N_REMOTE-1:0][SV_W-1:0]  score_cand;

    logic                           tx_pause_q, tx_pause_d;
    logic                           tx_reload_q, tx_reload_d;
    logic [SCORE_W-1:0]             tx_score_q, tx_score_d;
    logic [N_REMOTE-1:0]            rx_pause_q, rx_pause_d;
    logic [N_REMOTE-1:0]            rx_reload_q, rx_reload_d;
    logic [N_REMOTE-1:0]            rx_reload_pulse_q, rx_reload_pulse_d;
    logic [N_REMOTE*SCORE_W-1:0]    rx_score_q, rx_score_d;
    logic [N_REMOTE-1:0]            rx_score_upd_q, rx_score_upd_d;
    logic [N_REMOTE-1:0]            link_err_q, link_err_d;

    for (genvar g = 0; g < N_REMOTE; g++) begin : g_peer
        logic [SV_W-1:0] score_raw;
`ifdef PLAYER_LINK_PARITY_EN
        assign score_raw   = {rx_parity_raw[g], rx_score_raw[g*SCORE_W +: SCORE_W]};
        assign score_ok[g] = ~^score_cand[g];
`else
        assign score_raw   = rx_score_raw[g*SCORE_W +: SCORE_W];
        assign score_ok[g] = 1'b1;
`endif

        link_filter #(.W(1), .SYNC_STAGES(SYNC_STAGES), .STABLE_CYCLES(STABLE_CYCLES)) u_pause (
            .clk      (clk),
            .rst      (rst),
            .raw_i    (rx_pause_raw[g]),
            .accept_i (1'b1),
            .commit_o (pause_commit[g]),
            .cand_o   (pause_cand[g])
        );

        link_filter #(.W(1), .SYNC_STAGES(SYNC_STAGES), .STABLE_CYCLES(STABLE_CYCLES)) u_reload (
            .clk      (clk),
            .rst      (rst),
            .raw_i    (rx_reload_raw[g]),
            .accept_i (1'b1),
            .commit_o (reload_commit[g]),
            .cand_o   (reload_cand[g])
        );

        link_filter #(.W(SV_W), .SYNC_STAGES(SYNC_STAGES), .STABLE_CYCLES(STABLE_CYCLES)) u_score (
            .clk      (clk),
            .rst      (rst),
            .raw_i    (score_raw),
            .accept_i (score_ok[g]),
            .commit_o (score_commit[g]),
            .cand_o   (score_cand[g])
        );
    end

    always_comb begin
        tx_pause_d        = local_pause;
        tx_reload_d       = local_reload;
        tx_score_d        = local_score;
        rx_pause_d        = rx_pause_q;
        rx_reload_d       = rx_reload_q;
        rx_reload_pulse_d = '0;
        rx_score_d        = rx_score_q;
        rx_score_upd_d    = '0;
        // A fresh error in the same cycle as clr_err must survive the clear.
        link_err_d        = clr_err ? '0 : link_err_q;
        for (int k = 0; k < N_REMOTE; k++) begin
            if (pause_commit[k]) rx_pause_d[k] = pause_cand[k];
            if (reload_commit[k]) begin
                rx_reload_d[k]       = reload_cand[k];
                rx_reload_pulse_d[k] = reload_cand[k];
            end
            if (score_commit[k]) begin
                if (!score_ok[k]) begin
                    link_err_d[k] = 1'b1;
                end else begin
                    rx_score_d[k*SCORE_W +: SCORE_W] = score_cand[k][SCORE_W-1:0];
                    rx_score_upd_d[k] = 1'b1;
                    if (!score_legal(32'(rx_score_q[k*SCORE_W +: SCORE_W]),
                                     32'(score_cand[k][SCORE_W-1:0]), SCORE_W))
                        link_err_d[k] = 1'b1;
                end
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            tx_pause_q        <= 1'b0;
            tx_reload_q       <= 1'b0;
            tx_score_q        <= '0;
            rx_pause_q        <= '0;
            rx_reload_q       <= '0;
            rx_reload_pulse_q <= '0;
            rx_score_q        <= '0;
            rx_score_upd_q    <= '0;
            link_err_q        <= '0;
        end else begin
            tx_pause_q        <= tx_pause_d;
            tx_reload_q       <= tx_reload_d;
            tx_score_q        <= tx_score_d;
            rx_pause_q        <= rx_pause_d;
            rx_reload_q       <= rx_reload_d;
            rx_reload_pulse_q <= rx_reload_pulse_d;
            rx_score_q        <= rx_score_d;
            rx_score_upd_q    <= rx_score_upd_d;
            link_err_q        <= link_err_d;
        end
    end

`ifdef PLAYER_LINK_PARITY_EN
    logic tx_parity_q, tx_parity_d;
    assign tx_parity_d = ^local_score;
    always_ff @(posedge clk or posedge rst) begin
        if (rst) tx_parity_q <= 1'b0;
        else     tx_parity_q <= tx_parity_d;
    end
    assign tx_parity = tx_parity_q;
`endif

    assign tx_pause        = tx_pause_q;
    assign tx_reload       = tx_reload_q;
    assign tx_score        = tx_score_q;
    assign rx_pause        = rx_pause_q;
    assign rx_reload       = rx_reload_q;
    assign rx_reload_pulse = rx_reload_pulse_q;
    assign rx_score        = rx_score_q;
    assign rx_score_upd    = rx_score_upd_q;
    assign link_err        = link_err_q;

endmodule

// File: tb/tb_player_link.sv
// Scoreboard bench for player_link: a run-length reference model predicts every cycle's outputs,
// a negedge monitor pops and compares. Honours PLAYER_LINK_PARITY_EN when defined.
module tb_player_link;

    localparam int NR = 2;
    localparam int SW = 4;
    localparam int SC = 4;

    logic clk, rst, clr_err;
    logic local_pause, local_reload;
    logic [SW-1:0] local_score;
    logic tx_pause, tx_reload;
    logic [SW-1:0] tx_score;
    logic [NR-1:0] raw_pause, raw_reload;
    logic [NR*SW-1:0] raw_score;
    logic [NR-1:0] rx_pause, rx_reload, rx_reload_pulse, rx_score_upd, link_err;
    logic [NR*SW-1:0] rx_score;
`ifdef PLAYER_LINK_PARITY_EN
    logic tx_parity;
    logic [NR-1:0] raw_par;
`endif

    player_link #(.N_REMOTE(NR), .SCORE_W(SW), .SYNC_STAGES(2), .STABLE_CYCLES(SC)) dut (
        .clk             (clk),
        .rst             (rst),
        .clr_err         (clr_err),
        .local_pause     (local_pause),
        .local_reload    (local_reload),
        .local_score     (local_score),
        .tx_pause        (tx_pause),
        .tx_reload       (tx_reload),
        .tx_score        (tx_score),
`ifdef PLAYER_LINK_PARITY_EN
        .tx_parity       (tx_parity),
        .rx_parity_raw   (raw_par),
`endif
        .rx_pause_raw    (raw_pause),
        .rx_reload_raw   (raw_reload),
        .rx_score_raw    (raw_score),
        .rx_pause        (rx_pause),
        .rx_reload       (rx_reload),
        .rx_reload_pulse (rx_reload_pulse),
        .rx_score        (rx_score),
        .rx_score_upd    (rx_score_upd),
        .link_err        (link_err)
    );

    typedef struct packed {
        logic          tx_pause;
        logic          tx_reload;
        logic [3:0]    tx_score;
        logic          tx_par;
        logic [1:0]    pause;
        logic [1:0]    reload;
        logic [1:0]    rpulse;
        logic [1:0]    upd;
        logic [1:0]    err;
        logic [7:0]    score;
    } snap_t;

    snap_t exp_q[$];
    int n_checks = 0;
    int n_pass   = 0;

    // Model state: per peer, per field (0 pause, 1 reload, 2 score[+parity<<4]).
    int m_comm[2][3];
    int m_rval[2][3];
    int m_run[2][3];
    int hist[2][3][2];
    int m_err[2];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] expv);
        n_checks++;
        if (act === expv) n_pass++;
        else $display("FAIL %s at %0t: got %h expected %h", name, $time, act, expv);
    endtask

    function automatic bit step_legal(input int old_s, input int new_s);
        return (new_s == 0) || (new_s == (old_s + 1) % 16);
    endfunction

    function automatic bit parity_good(input int v);
`ifdef PLAYER_LINK_PARITY_EN
        return ($countones(v) % 2) == 0;
`else
        return v >= 0;
`endif
    endfunction

    initial begin
        clk = 0;
        forever #5 clk = ~clk;
    end

    always @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int k = 0; k < 2; k++) begin
                m_err[k] = 0;
                for (int f = 0; f < 3; f++) begin
                    m_comm[k][f] = 0; m_rval[k][f] = 0; m_run[k][f] = 0;
                    hist[k][f][0] = 0; hist[k][f][1] = 0;
                end
            end
            exp_q.delete();
        end else begin
            snap_t e;
            int seen;
            int r[3];
            e = '0;
            e.tx_pause  = local_pause;
            e.tx_reload = local_reload;
            e.tx_score  = local_score;
            e.tx_par    = ^local_score;
            for (int k = 0; k < 2; k++) begin
                r[0] = int'(raw_pause[k]);
                r[1] = int'(raw_reload[k]);
                r[2] = int'(raw_score[k*4 +: 4]);
`ifdef PLAYER_LINK_PARITY_EN
                r[2] = r[2] + (raw_par[k] ? 16 : 0);
`endif
                if (clr_err) m_err[k] = 0;
                for (int f = 0; f < 3; f++) begin
                    seen = hist[k][f][0];
                    hist[k][f][0] = hist[k][f][1];
                    hist[k][f][1] = r[f];
                    if (seen == m_comm[k][f]) m_run[k][f] = 0;
                    else if (m_run[k][f] > 0 && seen == m_rval[k][f]) m_run[k][f]++;
                    else begin
                        m_rval[k][f] = seen;
                        m_run[k][f]  = 1;
                    end
                    if (m_run[k][f] == SC + 1) begin
                        m_run[k][f] = 0;
                        if (f == 0) m_comm[k][f] = seen;
                        else if (f == 1) begin
                            m_comm[k][f] = seen;
                            e.rpulse[k] = (seen == 1);
                        end else if (!parity_good(seen)) m_err[k] = 1;
                        else begin
                            if (!step_legal(m_comm[k][f] % 16, seen % 16)) m_err[k] = 1;
                            m_comm[k][f] = seen;
                            e.upd[k] = 1'b1;
                        end
                    end
                end
                e.pause[k]       = (m_comm[k][0] != 0);
                e.reload[k]      = (m_comm[k][1] != 0);
                e.score[k*4 +: 4] = 4'(m_comm[k][2] % 16);
                e.err[k]         = (m_err[k] != 0);
            end
            exp_q.push_back(e);
        end
    end

    always @(negedge clk) begin
        if (!rst && exp_q.size() > 0) begin
            snap_t e;
            e = exp_q.pop_front();
            check("tx", 32'({tx_pause, tx_reload, tx_score}), 32'({e.tx_pause, e.tx_reload, e.tx_score}));
`ifdef PLAYER_LINK_PARITY_EN
            check("tx_parity", 32'(tx_parity), 32'(e.tx_par));
`endif
            check("rx_state", 32'({rx_pause, rx_reload, rx_score}), 32'({e.pause, e.reload, e.score}));
            check("strobes", 32'({rx_reload_pulse, rx_score_upd}), 32'({e.rpulse, e.upd}));
            check("link_err", 32'(link_err), 32'(e.err));
        end
    end

    task automatic tick(input int n);
        repeat (n) begin
            @(posedge clk);
            #2;
        end
    endtask

    task automatic set_score(input int k, input logic [3:0] v);
        raw_score[k*4 +: 4] = v;
`ifdef PLAYER_LINK_PARITY_EN
        raw_par[k] = ^v;
`endif
    endtask

    function automatic logic [31:0] all_outs();
        return 32'({tx_pause, tx_reload, tx_score, rx_pause, rx_reload, rx_reload_pulse,
                    rx_score, rx_score_upd, link_err});
    endfunction

    initial begin
        rst = 0; clr_err = 0;
        local_pause = 0; local_reload = 0; local_score = 0;
        raw_pause = 0; raw_reload = 0; raw_score = 0;
`ifdef PLAYER_LINK_PARITY_EN
        raw_par = 0;
`endif
        #1 rst = 1;
        repeat (3) @(posedge clk);
        #2;
        check("reset_state", all_outs(), 32'd0);
        rst = 0;
        local_score = 4'h3; local_pause = 1;
        tick(3);

        set_score(0, 4'd1);
        tick(12);

        raw_pause[1] = 1; tick(3);
        raw_pause[1] = 0; tick(8);
        raw_pause[1] = 1; tick(12);

        set_score(0, 4'd3);
        tick(12);
        clr_err = 1; tick(1);
        clr_err = 0; tick(2);
        set_score(0, 4'd0);
        tick(12);

        raw_reload = 2'b11; tick(12);
        raw_reload = 2'b00; tick(12);

        local_score = 4'h6;
        set_score(0, 4'd5);
        tick(12);
        rst = 1;
        #1;
        check("rst_async", all_outs(), 32'd0);
        tick(2);
        rst = 0;
        local_score = 4'h9; local_pause = 0; local_reload = 1;
        tick(14);

`ifdef PLAYER_LINK_PARITY_EN
        raw_score[3:0] = 4'd2; raw_par[0] = 1'b0;
        tick(14);
        raw_par[0] = 1'b1;
        tick(12);
`endif

        for (int it = 0; it < 90; it++) begin
            int k, sel, hold;
            logic [3:0] cur;
            k    = $urandom_range(0, 1);
            sel  = $urandom_range(0, 3);
            hold = $urandom_range(1, 9);
            local_pause  = 1'($urandom);
            local_reload = 1'($urandom);
            local_score  = 4'($urandom);
            cur = raw_score[k*4 +: 4];
            case (sel)
                0: raw_pause[k]  = ~raw_pause[k];
                1: raw_reload[k] = ~raw_reload[k];
                2: set_score(k, ($urandom_range(0, 3) == 0) ? 4'($urandom) : cur + 4'd1);
                default: begin
                    clr_err = 1; tick(1);
                    clr_err = 0;
                end
            endcase
`ifdef PLAYER_LINK_PARITY_EN
            if ($urandom_range(0, 7) == 0) raw_par[k] = ~raw_par[k];
`endif
            tick(hold);
        end
        tick(15);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
